// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core: ALU op codes, forward-select
// encodings and default datapath widths.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_WGHT = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    localparam logic [2:0] WGHT_CODE = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10,
        FWD_RSV = 2'b11
    } fwd_sel_e;

    function automatic logic isWght(input logic [2:0] aluOp);
        return (aluOp == WGHT_CODE);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// D-stage capture bundle and E-stage result bundle of the ID/EX pipeline register.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]        ALUControlD;
    logic [DATA_W-1:0] RD1D, RD2D, RD3D, SignImmD;
    logic [REG_W-1:0]  RsD, RtD, RdD;

    logic              RegWriteE, MemtoRegE, MemWriteE, ValidE;
    logic [2:0]        ALUControlE;
    logic [REG_W-1:0]  RsE, RtE, RdE, WriteRegE;
    logic [DATA_W-1:0] SrcAE, SrcBE, SrcCE, WriteDataE;

    modport master (
        output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
               RD1D, RD2D, RD3D, SignImmD, RsD, RtD, RdD,
        input  RegWriteE, MemtoRegE, MemWriteE, ValidE, ALUControlE,
               RsE, RtE, RdE, WriteRegE, SrcAE, SrcBE, SrcCE, WriteDataE
    );

    modport slave (
        input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
               RD1D, RD2D, RD3D, SignImmD, RsD, RtD, RdD,
        output RegWriteE, MemtoRegE, MemWriteE, ValidE, ALUControlE,
               RsE, RtE, RdE, WriteRegE, SrcAE, SrcBE, SrcCE, WriteDataE
    );
endinterface

// File: rtl/fwd_mux3.sv
// Operand forward select: register value, W-stage result or M-stage result.
// The reserved code (and any unknown select) falls back to the register value.
module fwd_mux3
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] regVal,
    input  logic [W-1:0] resultW,
    input  logic [W-1:0] aluOutM,
    output logic [W-1:0] y
);

    // Select the forwarded operand
    always_comb begin
        y = regVal;
        case (sel)
            FWD_REG: y = regVal;
            FWD_W:   y = resultW;
            FWD_M:   y = aluOutM;
            default: y = regVal;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-Execute pipeline register with bubble insertion, E-stage operand
// forwarding (including the WGHT third operand) and saturating perf counters.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              StallE,
    input  logic              FlushE,
    id_ex_stage_if.slave      pipe,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [1:0]        ForwardCE,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] ResultW,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic [CNT_W-1:0]  IssueCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              regWriteE_r, memtoRegE_r, memWriteE_r, aluSrcE_r, regDstE_r, validE_r;
    logic [2:0]        aluControlE_r;
    logic [DATA_W-1:0] rd1E_r, rd2E_r, rd3E_r, signImmE_r;
    logic [REG_W-1:0]  rsE_r, rtE_r, rdE_r;
    logic [CNT_W-1:0]  bubbleCnt_r, issueCnt_r;
    logic [DATA_W-1:0] fwdA_s, fwdB_s, fwdC_s;

    // E-stage register: stall holds, flush loads a bubble, otherwise capture D
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regWriteE_r   <= 1'b0;
            memtoRegE_r   <= 1'b0;
            memWriteE_r   <= 1'b0;
            aluSrcE_r     <= 1'b0;
            regDstE_r     <= 1'b0;
            validE_r      <= 1'b0;
            aluControlE_r <= 3'b000;
            rd1E_r        <= {DATA_W{1'b0}};
            rd2E_r        <= {DATA_W{1'b0}};
            rd3E_r        <= {DATA_W{1'b0}};
            signImmE_r    <= {DATA_W{1'b0}};
            rsE_r         <= {REG_W{1'b0}};
            rtE_r         <= {REG_W{1'b0}};
            rdE_r         <= {REG_W{1'b0}};
        end else if (StallE) begin
            validE_r      <= validE_r;
        end else if (FlushE) begin
            regWriteE_r   <= 1'b0;
            memtoRegE_r   <= 1'b0;
            memWriteE_r   <= 1'b0;
            aluSrcE_r     <= 1'b0;
            regDstE_r     <= 1'b0;
            validE_r      <= 1'b0;
            aluControlE_r <= 3'b000;
            rd1E_r        <= {DATA_W{1'b0}};
            rd2E_r        <= {DATA_W{1'b0}};
            rd3E_r        <= {DATA_W{1'b0}};
            signImmE_r    <= {DATA_W{1'b0}};
            rsE_r         <= {REG_W{1'b0}};
            rtE_r         <= {REG_W{1'b0}};
            rdE_r         <= {REG_W{1'b0}};
        end else begin
            regWriteE_r   <= pipe.RegWriteD;
            memtoRegE_r   <= pipe.MemtoRegD;
            memWriteE_r   <= pipe.MemWriteD;
            aluSrcE_r     <= pipe.ALUSrcD;
            regDstE_r     <= pipe.RegDstD;
            validE_r      <= 1'b1;
            aluControlE_r <= pipe.ALUControlD;
            rd1E_r        <= pipe.RD1D;
            rd2E_r        <= pipe.RD2D;
            rd3E_r        <= pipe.RD3D;
            signImmE_r    <= pipe.SignImmD;
            rsE_r         <= pipe.RsD;
            rtE_r         <= pipe.RtD;
            rdE_r         <= pipe.RdD;
        end
    end

    // Saturating bubble/issue counters; a stalled cycle counts as neither
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubbleCnt_r <= {CNT_W{1'b0}};
            issueCnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (!StallE && FlushE && (bubbleCnt_r != CNT_MAX)) begin
                bubbleCnt_r <= bubbleCnt_r + CNT_ONE;
            end
            if (!StallE && !FlushE && (issueCnt_r != CNT_MAX)) begin
                issueCnt_r <= issueCnt_r + CNT_ONE;
            end
        end
    end

    fwd_mux3 #(.W(DATA_W)) u_fwdA (
        .sel(ForwardAE), .regVal(rd1E_r), .resultW(ResultW), .aluOutM(ALUOutM), .y(fwdA_s)
    );
    fwd_mux3 #(.W(DATA_W)) u_fwdB (
        .sel(ForwardBE), .regVal(rd2E_r), .resultW(ResultW), .aluOutM(ALUOutM), .y(fwdB_s)
    );
    fwd_mux3 #(.W(DATA_W)) u_fwdC (
        .sel(ForwardCE), .regVal(rd3E_r), .resultW(ResultW), .aluOutM(ALUOutM), .y(fwdC_s)
    );

    assign pipe.RegWriteE   = regWriteE_r;
    assign pipe.MemtoRegE   = memtoRegE_r;
    assign pipe.MemWriteE   = memWriteE_r;
    assign pipe.ValidE      = validE_r;
    assign pipe.ALUControlE = aluControlE_r;
    assign pipe.RsE         = rsE_r;
    assign pipe.RtE         = rtE_r;
    assign pipe.RdE         = rdE_r;
    assign pipe.WriteRegE   = regDstE_r ? rdE_r : rtE_r;
    assign pipe.SrcAE       = fwdA_s;
    assign pipe.WriteDataE  = fwdB_s;
    assign pipe.SrcBE       = aluSrcE_r ? signImmE_r : fwdB_s;
    // ForwardCE is stale for non-WGHT ops, so only WGHT may use the forwarded value
    assign pipe.SrcCE       = isWght(aluControlE_r) ? fwdC_s : rd3E_r;
    assign BubbleCnt        = bubbleCnt_r;
    assign IssueCnt         = issueCnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table through a scoreboard queue,
// plus hand sequences for async reset, reset release and counter saturation.
module tb_id_ex_stage;

    typedef struct {
        logic        stall, flush, regWrite, memtoReg, memWrite, aluSrc, regDst;
        logic [2:0]  aluc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, rd3, imm;
        logic [1:0]  fa, fb, fc;
    } in_t;

    typedef struct {
        logic        valid, regWrite, memtoReg, memWrite;
        logic [2:0]  aluc;
        logic [4:0]  rs, rt, rd, writeReg;
        logic [31:0] srcA, srcB, srcC, wd;
        logic [15:0] bubble, issue;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int NV = 11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        StallE, FlushE, flush4;
    logic [1:0]  ForwardAE, ForwardBE, ForwardCE;
    logic [31:0] ALUOutM, ResultW;
    logic [15:0] BubbleCnt, IssueCnt;
    logic [3:0]  BubbleCnt4, IssueCnt4;

    int checks = 0;
    int failures = 0;

    vec_t tbl[NV];
    exp_t expQ[$];
    exp_t e;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5)) pif ();
    id_ex_stage_if #(.DATA_W(32), .REG_W(5)) pif4 ();

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE), .pipe(pif),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
        .ALUOutM(ALUOutM), .ResultW(ResultW), .BubbleCnt(BubbleCnt), .IssueCnt(IssueCnt)
    );

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .StallE(1'b0), .FlushE(flush4), .pipe(pif4),
        .ForwardAE(2'b00), .ForwardBE(2'b00), .ForwardCE(2'b00),
        .ALUOutM(32'h0), .ResultW(32'h0), .BubbleCnt(BubbleCnt4), .IssueCnt(IssueCnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic applyIn(input in_t v);
        StallE = v.stall;  FlushE = v.flush;
        pif.RegWriteD = v.regWrite; pif.MemtoRegD = v.memtoReg; pif.MemWriteD = v.memWrite;
        pif.ALUSrcD = v.aluSrc; pif.RegDstD = v.regDst; pif.ALUControlD = v.aluc;
        pif.RsD = v.rs; pif.RtD = v.rt; pif.RdD = v.rd;
        pif.RD1D = v.rd1; pif.RD2D = v.rd2; pif.RD3D = v.rd3; pif.SignImmD = v.imm;
        ForwardAE = v.fa; ForwardBE = v.fb; ForwardCE = v.fc;
    endtask

    task automatic cmpE(input int idx, input exp_t x);
        chk($sformatf("v%0d.ValidE", idx), {31'b0, pif.ValidE}, {31'b0, x.valid});
        chk($sformatf("v%0d.RegWriteE", idx), {31'b0, pif.RegWriteE}, {31'b0, x.regWrite});
        chk($sformatf("v%0d.MemtoRegE", idx), {31'b0, pif.MemtoRegE}, {31'b0, x.memtoReg});
        chk($sformatf("v%0d.MemWriteE", idx), {31'b0, pif.MemWriteE}, {31'b0, x.memWrite});
        chk($sformatf("v%0d.ALUControlE", idx), {29'b0, pif.ALUControlE}, {29'b0, x.aluc});
        chk($sformatf("v%0d.RsE", idx), {27'b0, pif.RsE}, {27'b0, x.rs});
        chk($sformatf("v%0d.RtE", idx), {27'b0, pif.RtE}, {27'b0, x.rt});
        chk($sformatf("v%0d.RdE", idx), {27'b0, pif.RdE}, {27'b0, x.rd});
        chk($sformatf("v%0d.WriteRegE", idx), {27'b0, pif.WriteRegE}, {27'b0, x.writeReg});
        chk($sformatf("v%0d.SrcAE", idx), pif.SrcAE, x.srcA);
        chk($sformatf("v%0d.SrcBE", idx), pif.SrcBE, x.srcB);
        chk($sformatf("v%0d.SrcCE", idx), pif.SrcCE, x.srcC);
        chk($sformatf("v%0d.WriteDataE", idx), pif.WriteDataE, x.wd);
        chk($sformatf("v%0d.BubbleCnt", idx), {16'b0, BubbleCnt}, {16'b0, x.bubble});
        chk($sformatf("v%0d.IssueCnt", idx), {16'b0, IssueCnt}, {16'b0, x.issue});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // inputs: stall,flush,regWrite,memtoReg,memWrite,aluSrc,regDst,aluc,rs,rt,rd,rd1,rd2,rd3,imm,fa,fb,fc
        // expect: valid,regWrite,memtoReg,memWrite,aluc,rs,rt,rd,writeReg,srcA,srcB,srcC,wd,bubble,issue
        tbl[0]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,3'b010,5'd2,5'd3,5'd7,32'h11,32'h22,32'h33,32'h4,2'b00,2'b00,2'b00},
                    '{1'b1,1'b1,1'b0,1'b0,3'b010,5'd2,5'd3,5'd7,5'd7,32'h11,32'h4,32'h33,32'h22,16'd0,16'd1}};
        tbl[1]  = '{'{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,3'b010,5'd5,5'd4,5'd9,32'h100,32'h200,32'h300,32'h8,2'b10,2'b01,2'b10},
                    '{1'b1,1'b1,1'b1,1'b0,3'b010,5'd5,5'd4,5'd9,5'd4,32'hAAAA,32'h5555,32'h300,32'h5555,16'd0,16'd2}};
        tbl[2]  = '{'{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,3'b010,5'd5,5'd4,5'd9,32'h100,32'h200,32'h300,32'h8,2'b11,2'b00,2'b10},
                    '{1'b1,1'b1,1'b1,1'b0,3'b010,5'd5,5'd4,5'd9,5'd4,32'h100,32'h200,32'h300,32'h200,16'd0,16'd3}};
        tbl[3]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'b101,5'd6,5'd8,5'd10,32'h100,32'h200,32'h777,32'h8,2'b00,2'b00,2'b10},
                    '{1'b1,1'b1,1'b0,1'b0,3'b101,5'd6,5'd8,5'd10,5'd8,32'h100,32'h200,32'hAAAA,32'h200,16'd0,16'd4}};
        tbl[4]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'b101,5'd6,5'd8,5'd10,32'h100,32'h200,32'h777,32'h8,2'b00,2'b10,2'b11},
                    '{1'b1,1'b1,1'b0,1'b0,3'b101,5'd6,5'd8,5'd10,5'd8,32'h100,32'hAAAA,32'h777,32'hAAAA,16'd0,16'd5}};
        tbl[5]  = '{'{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,3'b111,5'd31,5'd31,5'd31,32'hFFFF,32'hFFFF,32'hFFFF,32'hFFFF,2'b00,2'b00,2'b00},
                    '{1'b0,1'b0,1'b0,1'b0,3'b000,5'd0,5'd0,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,16'd1,16'd5}};
        tbl[6]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,3'b110,5'd1,5'd1,5'd31,32'hDEAD,32'hBEEF,32'h1,32'h10,2'b00,2'b00,2'b00},
                    '{1'b1,1'b1,1'b0,1'b1,3'b110,5'd1,5'd1,5'd31,5'd31,32'hDEAD,32'hBEEF,32'h1,32'hBEEF,16'd1,16'd6}};
        tbl[7]  = '{'{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,3'b000,5'd4,5'd4,5'd4,32'h9,32'h9,32'h9,32'h9,2'b00,2'b00,2'b00},
                    tbl[6].e};
        tbl[8]  = '{'{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'b000,5'd4,5'd4,5'd4,32'h9,32'h9,32'h9,32'h9,2'b00,2'b00,2'b00},
                    tbl[6].e};
        tbl[9]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,3'b101,5'd3,5'd12,5'd13,32'h1000,32'h2000,32'h3000,32'h40,2'b00,2'b00,2'b00},
                    '{1'b1,1'b1,1'b0,1'b0,3'b101,5'd3,5'd12,5'd13,5'd12,32'h1000,32'h40,32'h3000,32'h2000,16'd1,16'd7}};
        tbl[10] = '{'{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,3'b101,5'd3,5'd12,5'd13,32'h1000,32'h2000,32'h3000,32'h40,2'b01,2'b00,2'b10},
                    '{1'b0,1'b0,1'b0,1'b0,3'b000,5'd0,5'd0,5'd0,5'd0,32'h5555,32'h0,32'h0,32'h0,16'd2,16'd7}};

        applyIn(tbl[8].i);
        ALUOutM = 32'hAAAA;
        ResultW = 32'h5555;
        flush4  = 1'b0;
        pif4.RegWriteD = 1'b0; pif4.MemtoRegD = 1'b0; pif4.MemWriteD = 1'b0;
        pif4.ALUSrcD = 1'b0; pif4.RegDstD = 1'b0; pif4.ALUControlD = 3'b000;
        pif4.RsD = 5'd0; pif4.RtD = 5'd0; pif4.RdD = 5'd0;
        pif4.RD1D = 32'h0; pif4.RD2D = 32'h0; pif4.RD3D = 32'h0; pif4.SignImmD = 32'h0;
        ForwardAE = 2'b00;

        #12;
        chk("reset.ValidE", {31'b0, pif.ValidE}, 32'h0);
        chk("reset.RegWriteE", {31'b0, pif.RegWriteE}, 32'h0);
        chk("reset.SrcAE", pif.SrcAE, 32'h0);
        chk("reset.BubbleCnt", {16'b0, BubbleCnt}, 32'h0);
        chk("reset.IssueCnt", {16'b0, IssueCnt}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            applyIn(tbl[i].i);
            expQ.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            if (expQ.size() == 0) begin
                chk("scoreboard.empty", 32'h0, 32'h1);
            end else begin
                e = expQ.pop_front();
                cmpE(i, e);
            end
        end

        // Reset mid-operation, asserted between clock edges
        @(negedge clk);
        applyIn(tbl[0].i);
        @(posedge clk);
        #1;
        chk("midrst.pre.ValidE", {31'b0, pif.ValidE}, 32'h1);
        chk("midrst.pre.RegWriteE", {31'b0, pif.RegWriteE}, 32'h1);
        chk("midrst.pre.IssueCnt", {16'b0, IssueCnt}, 32'd8);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst.ValidE", {31'b0, pif.ValidE}, 32'h0);
        chk("midrst.RegWriteE", {31'b0, pif.RegWriteE}, 32'h0);
        chk("midrst.SrcAE", pif.SrcAE, 32'h0);
        chk("midrst.WriteDataE", pif.WriteDataE, 32'h0);
        chk("midrst.WriteRegE", {27'b0, pif.WriteRegE}, 32'h0);
        chk("midrst.BubbleCnt", {16'b0, BubbleCnt}, 32'h0);
        chk("midrst.IssueCnt", {16'b0, IssueCnt}, 32'h0);

        // Release: nothing changes until the next rising edge
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("release.ValidE", {31'b0, pif.ValidE}, 32'h0);
        @(posedge clk);
        #1;
        chk("release.edge.ValidE", {31'b0, pif.ValidE}, 32'h1);
        chk("release.edge.SrcAE", pif.SrcAE, 32'h11);
        chk("release.edge.IssueCnt", {16'b0, IssueCnt}, 32'h1);

        // Bubble counter saturation on the 4-bit instance
        chk("sat.start.BubbleCnt4", {28'b0, BubbleCnt4}, 32'h0);
        @(negedge clk);
        flush4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sat.3.BubbleCnt4", {28'b0, BubbleCnt4}, 32'h3);
        repeat (17) @(posedge clk);
        #1;
        chk("sat.20.BubbleCnt4", {28'b0, BubbleCnt4}, 32'hF);
        @(negedge clk);
        flush4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-Execute pipeline register for the 5-stage MIPS core; it consumes the hazard unit's `FlushE`, `ForwardAE`, `ForwardBE` and `ForwardCE` outputs.
- Captures D-stage control and operands, inserts bubbles on flush, and drives the E-stage operand forwarding muxes, including the third operand of WGHT.
- Feeds the `RsE`/`RtE`/`RdE`/`ALUControlE`/`WriteRegE`/`MemtoRegE`/`RegWriteE` signals back to the hazard unit.
- Keeps saturating bubble and issue counters for performance debug.

Parameters:
- DATA_W, 32, datapath width
- REG_W, 5, register-specifier width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- StallE  in  1  hold E register (tied 0 by current hazard unit; reserved for multi-cycle ALU)
- FlushE  in  1  insert bubble into E
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode controls
- ALUControlD  in  3  ALU op
- RD1D, RD2D, RD3D  in  DATA_W  register-file reads (Rs, Rt, Rd)
- SignImmD  in  DATA_W  extended immediate
- RsD, RtD, RdD  in  REG_W  specifiers
- ForwardAE, ForwardBE, ForwardCE  in  2 each  forward selects from hazard unit
- ALUOutM  in  DATA_W  M-stage result
- ResultW  in  DATA_W  W-stage result
- RegWriteE, MemtoRegE, MemWriteE  out  1 each  registered controls
- ALUControlE  out  3  registered ALU op
- RsE, RtE, RdE  out  REG_W  registered specifiers
- WriteRegE  out  REG_W  destination register
- SrcAE, SrcBE, SrcCE  out  DATA_W  ALU operands
- WriteDataE  out  DATA_W  store data
- ValidE  out  1  E holds a real instruction
- BubbleCnt, IssueCnt  out  CNT_W  performance counters

Behaviour:
- Reset (async, reset_n=0): every registered field is 0 and ValidE=0.
  - Outputs therefore read RegWriteE=MemtoRegE=MemWriteE=0, ALUControlE=000, all specifiers 0, all operands 0.
  - BubbleCnt=IssueCnt=0.
  - Deassertion takes effect on the next rising clk.
- Each rising clk, priority is:
  1. StallE=1: hold all fields. Stall wins over FlushE so an in-flight instruction is never lost.
  2. FlushE=1: load a bubble. All controls, specifiers, ALUControlE and data fields become 0, and ValidE=0.
  3. Otherwise: capture all D inputs and set ValidE=1.
- Latency is one cycle, D to E.
- WriteRegE = RegDstE ? RdE : RtE. It is combinational from the registered fields.
- Forward mux for A, B and C, with the register value being RD1E, RD2E or RD3E respectively:
  - 00 selects the register value.
  - 01 selects ResultW.
  - 10 selects ALUOutM.
  - 11 is reserved and selects the register value.
- SrcAE = fwdA.
- WriteDataE = fwdB.
- SrcBE = ALUSrcE ? SignImmE : fwdB.
- SrcCE = fwdC only when ALUControlE == WGHT_CODE (3'b101); otherwise SrcCE = RD3E and ForwardCE is ignored. This is required because the hazard unit does not update ForwardCE for non-WGHT ops.
- Forward muxes are purely combinational.
- Counters:
  - BubbleCnt increments on a flush-load cycle (FlushE & ~StallE).
  - IssueCnt increments on a capture cycle (~StallE & ~FlushE).
  - Both saturate at all-ones with no wrap.
- No X may propagate from the reserved select code.

Decomposition:
- Shared package mips_pkg holds:
  - WGHT_CODE = 3'b101
  - FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - ALU op codes
  - DATA_W and REG_W defaults
- One sub-module, fwd_mux3, holds the 3-input forward select with reserved-code fallback. It is instantiated three times.
- Counters stay inline.

Test Plan:
- Reset mid-operation:
  - Stimulus: capture an instruction with ValidE=1 and RegWriteE=1, then pull reset_n low between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clk edge.
- Normal capture:
  - Stimulus: RD1D=0x11, RD2D=0x22, SignImmD=0x4, ALUSrcD=1, RegDstD=1, RdD=7, RtD=3.
  - Response: next cycle SrcAE=0x11, SrcBE=0x4, WriteDataE=0x22, WriteRegE=7, ValidE=1, IssueCnt=1.
- Forwarding:
  - Stimulus: ALUOutM=0xAAAA, ResultW=0x5555, ForwardAE=10, ForwardBE=01, ALUSrcE=0.
  - Response: SrcAE=0xAAAA, SrcBE=0x5555. With ForwardAE=11, SrcAE=RD1E.
- WGHT third operand:
  - Stimulus: ALUControlE=101, ForwardCE=10. Then ALUControlE=010 with ForwardCE=10.
  - Response: first case SrcCE=ALUOutM; second case SrcCE=RD3E.
- Flush vs stall:
  - Stimulus: FlushE=1 alone, then FlushE=1 with StallE=1.
  - Response: FlushE alone gives a bubble (RegWriteE=0, ALUControlE=000, ValidE=0, BubbleCnt+1). FlushE with StallE holds the prior contents and leaves BubbleCnt unchanged.
- Counter saturation:
  - Stimulus: CNT_W=4, drive 20 flushes.
  - Response: BubbleCnt stops at 0xF.
